// File: rtl/game_tracker_pkg.sv
// Shared types and width helpers for the game tracker.
// Optional walk handling is enabled with GAME_TRACKER_WALK_EN.
package game_tracker_pkg;

  typedef enum logic [1:0] {
    EV_HIT  = 2'd0,
    EV_OUT  = 2'd1,
    EV_WALK = 2'd2,
    EV_RSVD = 2'd3
  } ev_type_e;

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_CHANGE = 2'd1,
    ST_OVER   = 2'd2
  } state_e;

  // Width holding 0..n_bases+1, the largest hit length and the largest run count.
  function automatic int unsigned len_w(input int unsigned n_bases);
    return $clog2(n_bases + 2);
  endfunction

  // Width of a counter that never reaches n (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/game_tracker_if.sv
// Play-event handshake between the play-input decoder (master) and the tracker (slave).
interface game_tracker_if #(
  parameter int unsigned N_BASES = 3
) ();

  logic                                         ev_valid;
  logic                                         ev_ready;
  game_tracker_pkg::ev_type_e                   ev_type;
  logic [game_tracker_pkg::len_w(N_BASES)-1:0]  ev_len;

  modport master (output ev_valid, ev_type, ev_len, input ev_ready);
  modport slave  (input ev_valid, ev_type, ev_len, output ev_ready);

endinterface

// File: rtl/game_tracker_runner_advance.sv
// Combinational runner movement: next base occupancy, runs scored and illegal-event flag.
// WALK is only decoded when GAME_TRACKER_WALK_EN is defined.
module game_tracker_runner_advance
  import game_tracker_pkg::*;
#(
  parameter int unsigned N_BASES = 3
) (
  input  logic [N_BASES-1:0]          bases,
  input  ev_type_e                    ev_type,
  input  logic [len_w(N_BASES)-1:0]   ev_len,
  output logic [N_BASES-1:0]          next_bases,
  output logic [len_w(N_BASES)-1:0]   runs,
  output logic                        illegal
);

  localparam int unsigned LW = len_w(N_BASES);

`ifdef GAME_TRACKER_WALK_EN
  logic walk_found;
`endif

  always_comb begin
    next_bases = bases;
    runs       = '0;
    illegal    = 1'b0;
`ifdef GAME_TRACKER_WALK_EN
    walk_found = 1'b0;
`endif
    case (ev_type)
      EV_HIT: begin
        if (ev_len == '0 || int'(ev_len) > int'(N_BASES) + 1) begin
          illegal = 1'b1;
        end else if (int'(ev_len) == int'(N_BASES) + 1) begin
          // Home run clears the bases and scores the batter too.
          for (int i = 0; i < int'(N_BASES); i++) begin
            runs = runs + LW'(bases[i]);
          end
          runs       = runs + LW'(1);
          next_bases = '0;
        end else begin
          // Runners on the top k bases are pushed past home.
          for (int i = 0; i < int'(N_BASES); i++) begin
            if (i >= int'(N_BASES) - int'(ev_len)) begin
              runs = runs + LW'(bases[i]);
            end
          end
          next_bases = (bases << ev_len) | (N_BASES'(1) << (ev_len - LW'(1)));
        end
      end
      EV_OUT: begin
        runs = '0;
      end
`ifdef GAME_TRACKER_WALK_EN
      EV_WALK: begin
        // Forced advance fills the lowest empty base; loaded bases force one run in.
        for (int i = 0; i < int'(N_BASES); i++) begin
          if (!walk_found && !bases[i]) begin
            next_bases[i] = 1'b1;
            walk_found    = 1'b1;
          end
        end
        if (!walk_found) begin
          runs = LW'(1);
        end
      end
`endif
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/game_tracker.sv
// Game state tracker: bases, outs, half-innings and saturating scores from a play-event stream.
// Define GAME_TRACKER_WALK_EN to accept WALK events; otherwise they are rejected as illegal.
module game_tracker
  import game_tracker_pkg::*;
#(
  parameter int unsigned N_BASES         = 3,
  parameter int unsigned OUTS_PER_INNING = 3,
  parameter int unsigned INNINGS         = 9,
  parameter int unsigned SCORE_W         = 8,
  parameter int unsigned INN_W           = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  game_tracker_if.slave                       ev,
  output logic [N_BASES-1:0]                  bases,
  output logic [cnt_w(OUTS_PER_INNING)-1:0]   outs,
  output logic [len_w(N_BASES)-1:0]           runs,
  output logic                                runs_valid,
  output logic [SCORE_W-1:0]                  score_away,
  output logic [SCORE_W-1:0]                  score_home,
  output logic [INN_W-1:0]                    half_inning,
  output logic                                game_over,
  output logic                                ev_err
);

  localparam int unsigned LW = len_w(N_BASES);
  localparam int unsigned OW = cnt_w(OUTS_PER_INNING);

  state_e               state;
  logic [N_BASES-1:0]   adv_bases;
  logic [LW-1:0]        adv_runs;
  logic                 adv_illegal;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_sat;
  logic [INN_W-1:0]     half_next;
  logic                 last_out;
  logic                 game_end;

  game_tracker_runner_advance #(
    .N_BASES (N_BASES)
  ) u_advance (
    .bases      (bases),
    .ev_type    (ev.ev_type),
    .ev_len     (ev.ev_len),
    .next_bases (adv_bases),
    .runs       (adv_runs),
    .illegal    (adv_illegal)
  );

  // Batting team's score plus this event's runs, clamped at all-ones.
  always_comb begin
    score_sum = {1'b0, (half_inning[0] ? score_home : score_away)} + (SCORE_W+1)'(adv_runs);
    score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    half_next = (half_inning == '1) ? half_inning : half_inning + INN_W'(1);
    last_out  = (int'(outs) + 1 >= int'(OUTS_PER_INNING));
    // Regulation over, a top half about to start, and no tie.
    game_end  = (int'(half_inning) >= 2 * int'(INNINGS)) && !half_inning[0] &&
                (score_away != score_home);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_PLAY;
      ev.ev_ready <= 1'b1;
      bases       <= '0;
      outs        <= '0;
      runs        <= '0;
      runs_valid  <= 1'b0;
      score_away  <= '0;
      score_home  <= '0;
      half_inning <= '0;
      game_over   <= 1'b0;
      ev_err      <= 1'b0;
    end else begin
      runs_valid <= 1'b0;
      ev_err     <= 1'b0;
      case (state)
        ST_PLAY: begin
          if (ev.ev_valid) begin
            if (adv_illegal) begin
              ev_err <= 1'b1;
            end else if (ev.ev_type == EV_OUT) begin
              runs       <= '0;
              runs_valid <= 1'b1;
              if (last_out) begin
                state       <= ST_CHANGE;
                ev.ev_ready <= 1'b0;
                bases       <= '0;
                outs        <= '0;
                half_inning <= half_next;
              end else begin
                outs <= outs + OW'(1);
              end
            end else begin
              bases      <= adv_bases;
              runs       <= adv_runs;
              runs_valid <= 1'b1;
              if (half_inning[0]) begin
                score_home <= score_sat;
              end else begin
                score_away <= score_sat;
              end
            end
          end
        end
        ST_CHANGE: begin
          if (game_end) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
          end else begin
            state       <= ST_PLAY;
            ev.ev_ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_OVER;
        end
      endcase
    end
  end

endmodule
